// File: rtl/vga_reg_snapshot.sv
// Once per video frame, reads one page of CPU registers over the shared debug port.
// The page is published on regfiles in a single edge, so the text overlay never tears.
//
// state | meaning
// IDLE  | waiting for frame_start
// REQ   | debug port requested, no grant seen yet
// RUN   | issuing page addresses whenever the port is granted
// DRAIN | last word in flight; capture it and commit the page
module vga_reg_snapshot #(
    parameter int NREG    = 8,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 frame_start,
    input  logic [1:0]           page,
    output logic                 dbg_req,
    input  logic                 dbg_gnt,
    output logic [AW-1:0]        dbg_addr,
    input  logic [DW-1:0]        dbg_rdata,
    output logic [NREG*DW-1:0]   regfiles,
    output logic                 snap_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 overrun
);

    localparam int IW = $clog2(NREG + 1);
    localparam int SW = $clog2(NREG);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RUN, S_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [1:0]    page_q;
    logic [IW-1:0] issue_idx, cap_idx;
    logic [TW-1:0] tmo_cnt;
    logic          cap_fire;
    logic [DW-1:0] shadow [NREG];
    logic          issue_fire, tmo_hit, commit, start;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dbg_req    = 1'b0;
        busy       = (state != S_IDLE);
        issue_fire = 1'b0;
        tmo_hit    = 1'b0;
        commit     = 1'b0;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    start     = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ, S_RUN: begin
                dbg_req    = 1'b1;
                issue_fire = dbg_gnt && (issue_idx < IW'(NREG));
                if (issue_fire)
                    state_nxt = (issue_idx == IW'(NREG - 1)) ? S_DRAIN : S_RUN;
                else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                commit    = cap_fire && (cap_idx == IW'(NREG - 1));
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address only meaningful on an issue cycle; parked at zero otherwise.
    assign dbg_addr = issue_fire ?
        AW'(32'(page_q) * 32'(NREG) + 32'(issue_idx)) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            page_q     <= '0;
            issue_idx  <= '0;
            cap_idx    <= '0;
            tmo_cnt    <= '0;
            cap_fire   <= 1'b0;
            regfiles   <= '0;
            snap_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NREG; i++) shadow[i] <= '0;
        end else begin
            done     <= commit;
            err      <= tmo_hit;
            overrun  <= frame_start && busy;
            cap_fire <= issue_fire;
            if (start) begin
                page_q    <= page;
                issue_idx <= '0;
                cap_idx   <= '0;
                tmo_cnt   <= '0;
            end else begin
                if (issue_fire) begin
                    issue_idx <= issue_idx + 1'b1;
                    tmo_cnt   <= '0;
                end else if (state == S_REQ || state == S_RUN) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                if (cap_fire && state != S_IDLE) begin
                    shadow[cap_idx[SW-1:0]] <= dbg_rdata;
                    cap_idx                 <= cap_idx + 1'b1;
                end
            end
            // The last word bypasses the shadow so the whole page lands on one edge.
            if (commit) begin
                for (int i = 0; i < NREG; i++)
                    regfiles[DW*i +: DW] <= (i == NREG - 1) ? dbg_rdata : shadow[i];
                snap_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_reg_snapshot.sv
// Directed bench for vga_reg_snapshot: a fake register file answers one cycle after
// each address, and every scenario task checks its own expected values.
module tb_vga_reg_snapshot;

    localparam int NREG = 8;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                frame_start = 1'b0;
    logic [1:0]          page = 2'd0;
    logic                dbg_req;
    logic                dbg_gnt = 1'b0;
    logic [AW-1:0]       dbg_addr;
    logic [DW-1:0]       dbg_rdata = '0;
    logic [NREG*DW-1:0]  regfiles;
    logic                snap_valid, busy, done, err, overrun;

    int errors = 0;
    int checks = 0;

    vga_reg_snapshot #(.NREG(NREG), .DW(DW), .AW(AW), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .page(page),
        .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata), .regfiles(regfiles), .snap_valid(snap_valid),
        .busy(busy), .done(done), .err(err), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    // Register file model: r[a] = 0x1000_0000 + a, data one cycle after the address.
    always @(posedge CLK) dbg_rdata <= 32'h1000_0000 + 32'(dbg_addr);

    function automatic logic [NREG*DW-1:0] page_image(input int p);
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[DW*i +: DW] = 32'h1000_0000 + 32'(8*p + i);
        return v;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (regfiles !== '0 || dbg_req !== 1'b0 || busy !== 1'b0 || snap_valid !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || overrun !== 1'b0 || dbg_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%b busy=%b valid=%b done=%b err=%b ovr=%b addr=%0d regs=%h, required all zero",
                     dbg_req, busy, snap_valid, done, err, overrun, dbg_addr, regfiles);
        end
        @(negedge CLK); RST = 1'b0;
    endtask

    task automatic test_basic();
        logic [NREG*DW-1:0] exp_v;
        exp_v = page_image(0);
        page = 2'd0; dbg_gnt = 1'b1;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK); frame_start = 1'b0; #1;
            if (c <= 8) begin
                checks++;
                if (dbg_addr !== AW'(c - 1) || dbg_req !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_addr c=%0d: addr=%0d req=%b, required addr=%0d req=1", c, dbg_addr, dbg_req, c - 1);
                end
            end else if (c == 9) begin
                checks++;
                if (dbg_req !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_drain: req=%b busy=%b done=%b, required 0 1 0", dbg_req, busy, done);
                end
            end else if (c == 10) begin
                checks++;
                if (done !== 1'b1 || snap_valid !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done: done=%b valid=%b busy=%b, required 1 1 0", done, snap_valid, busy);
                end
                checks++;
                if (regfiles[31:0] !== 32'h1000_0000 || regfiles[255:224] !== 32'h1000_0007) begin
                    errors++;
                    $display("FAIL basic_ends: r0=%h r7=%h, required 10000000 10000007", regfiles[31:0], regfiles[255:224]);
                end
                checks++;
                if (regfiles !== exp_v) begin
                    errors++;
                    $display("FAIL basic_regs: got %h, required %h", regfiles, exp_v);
                end
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done_width: done=%b one cycle after commit, required 0", done);
                end
            end
        end
    endtask

    task automatic test_page_select();
        logic [NREG*DW-1:0] exp_v;
        exp_v = page_image(3);
        page = 2'd3; dbg_gnt = 1'b1;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK); frame_start = 1'b0;
            if (c == 3) page = 2'd1;
            #1;
            if (c <= 8) begin
                checks++;
                if (dbg_addr !== AW'(24 + c - 1)) begin
                    errors++;
                    $display("FAIL page_addr c=%0d: addr=%0d, required %0d", c, dbg_addr, 24 + c - 1);
                end
            end else if (c == 10) begin
                checks++;
                if (regfiles !== exp_v || done !== 1'b1) begin
                    errors++;
                    $display("FAIL page_regs: done=%b got %h, required done=1 %h", done, regfiles, exp_v);
                end
            end
        end
    endtask

    task automatic test_grant_stall();
        logic [NREG*DW-1:0] old_v, exp_v;
        old_v = page_image(3);
        exp_v = page_image(2);
        page = 2'd2; dbg_gnt = 1'b1;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge CLK); frame_start = 1'b0;
            dbg_gnt = !(c >= 5 && c <= 9);
            #1;
            if (c <= 4 || (c >= 10 && c <= 13)) begin
                checks++;
                if (dbg_addr !== AW'(16 + (c <= 4 ? c - 1 : c - 6)) || dbg_req !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_addr c=%0d: addr=%0d req=%b, required addr=%0d req=1",
                             c, dbg_addr, dbg_req, 16 + (c <= 4 ? c - 1 : c - 6));
                end
            end else if (c == 7) begin
                checks++;
                if (dbg_req !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: req=%b busy=%b while gnt low, required 1 1", dbg_req, busy);
                end
            end else if (c == 14) begin
                checks++;
                if (regfiles !== old_v || done !== 1'b0 || dbg_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_pre_commit: done=%b req=%b got %h, required done=0 req=0 %h",
                             done, dbg_req, regfiles, old_v);
                end
            end else if (c == 15) begin
                checks++;
                if (regfiles !== exp_v || done !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_commit: done=%b got %h, required done=1 %h", done, regfiles, exp_v);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [NREG*DW-1:0] old_v, exp_v;
        old_v = page_image(2);
        exp_v = page_image(1);
        page = 2'd1; dbg_gnt = 1'b0;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            @(negedge CLK); frame_start = 1'b0; #1;
            if (c == 64) begin
                checks++;
                if (dbg_req !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: req=%b err=%b at cycle 64, required 1 0", dbg_req, err);
                end
            end else if (c == 65) begin
                checks++;
                if (err !== 1'b1 || dbg_req !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_abort: err=%b req=%b busy=%b, required 1 0 0", err, dbg_req, busy);
                end
            end else if (c == 66) begin
                checks++;
                if (err !== 1'b0 || regfiles !== old_v || snap_valid !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_keep: err=%b valid=%b done=%b got %h, required 0 1 0 %h",
                             err, snap_valid, done, regfiles, old_v);
                end
            end
        end
        dbg_gnt = 1'b1;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK); frame_start = 1'b0; #1;
        end
        checks++;
        if (done !== 1'b1 || regfiles !== exp_v) begin
            errors++;
            $display("FAIL timeout_recover: done=%b got %h, required done=1 %h", done, regfiles, exp_v);
        end
    endtask

    task automatic test_overrun();
        int issues, dones;
        issues = 0; dones = 0;
        page = 2'd0; dbg_gnt = 1'b1;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK); frame_start = (c == 4 || c == 9); #1;
            if (dbg_req === 1'b1 && dbg_gnt === 1'b1) issues++;
            if (done === 1'b1) dones++;
            if (c == 5 || c == 10) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_pulse c=%0d: overrun=%b, required 1", c, overrun);
                end
            end else if (c == 6) begin
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun_width: overrun=%b, required 0", overrun);
                end
            end
        end
        frame_start = 1'b0;
        checks++;
        if (issues != 8 || dones != 1) begin
            errors++;
            $display("FAIL overrun_once: issues=%0d dones=%0d, required 8 1", issues, dones);
        end
        checks++;
        if (regfiles !== page_image(0)) begin
            errors++;
            $display("FAIL overrun_regs: got %h, required %h", regfiles, page_image(0));
        end
    endtask

    task automatic test_async_reset();
        page = 2'd0; dbg_gnt = 1'b1;
        @(negedge CLK); frame_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK); frame_start = 1'b0; #1;
        end
        checks++;
        if (dbg_addr !== AW'(5) || dbg_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: addr=%0d req=%b, required 5 1", dbg_addr, dbg_req);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (dbg_req !== 1'b0 || busy !== 1'b0 || regfiles !== '0 || snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_drop: req=%b busy=%b valid=%b regs=%h, required 0 0 0 0",
                     dbg_req, busy, snap_valid, regfiles);
        end
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle: busy=%b done=%b after release, required 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_page_select();
        test_grant_stall();
        test_timeout();
        test_overrun();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
